cas_ddram_ctrl: RTL and testbench
=================================

Name: cas_ddram_ctrl

Overview:
- Owns the single DDRAM Avalon port used for cassette (CAS) images and shares it between two users.
- Writer: the HPS ioctl download stream, index 2, byte writes.
- Reader: the tape playback engine, byte reads.
- Write bytes are packed into 64-bit words. Reads go through a one-word cache. Write commits have priority over reads.

Parameters:
- BASE_ADDR, 29'h0600_0000, DDRAM 64-bit word address of byte 0 of the tape image.

Ports:
- clk_sys  in  1  system clock; DDRAM_CLK is driven from it.
- reset  in  1  synchronous, active-high reset.
- wr_addr  in  25  byte address of the download byte.
- wr_data  in  8  download byte.
- wr_strobe  in  1  one-cycle byte-write pulse; sampled only while wr_wait=0.
- wr_flush  in  1  one-cycle pulse at end of download; commits the buffer if dirty.
- wr_wait  out  1  stall, drives ioctl_wait.
- rd_addr  in  25  byte address to read; sampled with rd_req.
- rd_req  in  1  one-cycle read pulse; ignored while rd_busy=1.
- rd_busy  out  1  high from the cycle after an accepted rd_req until rd_valid.
- rd_data  out  8  read byte; holds its value after rd_valid.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- DDRAM_CLK  out  1  equals clk_sys.
- DDRAM_BUSY  in  1  Avalon waitrequest.
- DDRAM_BURSTCNT  out  8  always 1.
- DDRAM_ADDR  out  29  word address, BASE_ADDR + addr[24:3].
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data; byte lane n = addr[2:0]==n.
- DDRAM_BE  out  8  write byte enables.
- DDRAM_WE  out  1  write command.

Behaviour:
- Reset values:
  - DDRAM_RD=0, DDRAM_WE=0, DDRAM_BURSTCNT=1, DDRAM_ADDR=0, DDRAM_DIN=0, DDRAM_BE=0.
  - wr_wait=0, rd_busy=0, rd_valid=0, rd_data=0.
  - Write buffer clean, cache invalid, hold and read-pending flags clear, FSM=IDLE.
- Write buffer state: buf_data[63:0], buf_be[7:0], buf_tag[21:0], dirty.
- Accepted wr_strobe, buffer clean or tag==wr_addr[24:3]:
  - Merge the byte into lane wr_addr[2:0], set that BE bit, set dirty, set tag.
  - If BE becomes 8'hFF, request a commit.
- Accepted wr_strobe, buffer dirty and tag mismatch:
  - Capture the byte in the hold register and request a commit of the old buffer.
  - wr_wait=1 from the next cycle.
  - After the commit completes, merge the held byte into the now-clean buffer in the following cycle, then drop wr_wait.
- wr_flush: request a commit if dirty. If clean, no action.
- wr_flush and wr_strobe in the same cycle: merge the strobe byte first, then commit.
- wr_wait=1 while a commit is requested or in progress, or while the hold register is full.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - A pending commit goes to WR_ISSUE. This has priority.
  - Otherwise, a pending read that hits in the cache goes to RD_RESP.
  - Otherwise, a pending read that misses goes to RD_ISSUE.
- WR_ISSUE:
  - Drive DDRAM_WE=1 with ADDR, DIN, BE, all held stable while DDRAM_BUSY=1.
  - On the edge with DDRAM_BUSY=0: drop WE, clear dirty and BE.
  - If buf_tag equals the cache tag, invalidate the cache.
  - Go to IDLE.
- Read coherency: if a pending read's addr[24:3] equals a dirty buf_tag, force a commit before the read is serviced.
- Read accept: rd_req is latched into a pending flag and address. rd_busy=1 from the next cycle.
- Read hit (cache valid, tag match): RD_RESP is entered the cycle after acceptance. rd_valid pulses in RD_RESP (2 cycles after rd_req) with cache byte addr[2:0].
- Read miss:
  - RD_ISSUE: drive DDRAM_RD=1 held until DDRAM_BUSY=0, then go to RD_WAIT.
  - RD_WAIT: on DDRAM_DOUT_READY, load the cache with data and tag and set it valid, then go to RD_RESP.
- RD_RESP: rd_valid=1, rd_busy drops the same cycle, return to IDLE.
- DDRAM_DOUT_READY outside RD_WAIT is ignored.
- rd_req during a write commit is latched and served after the commit.
- Address wrap: addr[24:3] is added to BASE_ADDR modulo 2^29. No overflow flag.
- Reset mid-operation returns everything to the reset state on the next edge:
  - Any in-flight command is abandoned.
  - Late DOUT_READY is ignored.
  - Buffered, unflushed bytes are lost.

Test Plan:
- Write bytes 0x11..0x88 to addrs 0..7 -> exactly one DDRAM write with ADDR=0x0600_0000, DIN=0x8877665544332211, BE=0xFF; wr_wait low throughout except during the commit.
- Write 0xAA@3, then 0xBB@8 -> wr_wait rises; write ADDR=0x0600_0000, BE=0x08, DIN[31:24]=0xAA; then wr_flush -> ADDR=0x0600_0001, BE=0x01, DIN[7:0]=0xBB.
- Commit with DDRAM_BUSY held 5 cycles -> WE, ADDR, DIN, BE stable for all 5 cycles, single accepted transfer.
- Read addr 0x13 on cold cache, DOUT=0x0102030405060708 after 10 cycles -> one RD, ADDR=0x0600_0002, rd_data=0x05, rd_valid one pulse. Then read 0x17 -> no DDRAM_RD, rd_data=0x01, rd_valid 2 cycles after rd_req.
- Dirty buffer tag 2 holding 0xCC@0x10, then read 0x10 -> write commit precedes RD; cache refilled from DDRAM.
- Assert reset during RD_WAIT, then pulse DOUT_READY -> all outputs at reset values, no rd_valid, cache invalid; next read of the same address issues a new RD.

Source files
------------

// File: rtl/cas_ddram_ctrl.sv
// Cassette-image DDRAM port controller.
// Shares one Avalon DDRAM port between the HPS download stream (byte writes
// packed into 64-bit words) and the tape playback engine (byte reads through
// a one-word cache). Pending write commits always win over reads, and a read
// that targets the dirty write buffer forces that buffer out to DDRAM first.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | arbitrate: commit first, then cache hit, then cache miss
// S_WR_ISSUE | write command held on the bus until DDRAM_BUSY drops
// S_RD_ISSUE | read command held on the bus until DDRAM_BUSY drops
// S_RD_WAIT  | waiting for DDRAM_DOUT_READY to refill the cache
// S_RD_RESP  | rd_valid pulse, byte already in rd_data
module cas_ddram_ctrl #(
    parameter logic [28:0] BASE_ADDR = 29'h0600_0000
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic [24:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_strobe,
    input  logic        wr_flush,
    output logic        wr_wait,

    input  logic [24:0] rd_addr,
    input  logic        rd_req,
    output logic        rd_busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,

    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_RESP  = 3'd4;

    logic [2:0]  state;

    logic [63:0] buf_data;
    logic [7:0]  buf_be;
    logic [21:0] buf_tag;
    logic        dirty;
    logic        commit_req;
    logic        flush_pend;

    logic        hold_valid;
    logic [24:0] hold_addr;
    logic [7:0]  hold_data;

    logic        rd_pend;
    logic [24:0] rd_pend_addr;

    logic [63:0] cache_data;
    logic [21:0] cache_tag;
    logic        cache_valid;

    logic        strobe_acc;
    logic        strobe_merge;
    logic        strobe_spill;
    logic        hold_merge;
    logic        merge;
    logic [2:0]  m_lane;
    logic [7:0]  m_byte;
    logic [21:0] m_tag;
    logic [7:0]  be_next;
    logic        flush_any;
    logic        commit_done;
    logic        commit_start;
    logic [21:0] rd_tag;
    logic        rd_go;
    logic        rd_conflict;
    logic        rd_hit;
    logic        enter_resp;
    logic [7:0]  cache_byte;

    assign DDRAM_CLK      = clk_sys;
    assign DDRAM_BURSTCNT = 8'd1;
    assign wr_wait        = commit_req | hold_valid | (state == S_WR_ISSUE);
    assign rd_busy        = rd_pend;
    assign rd_valid       = (state == S_RD_RESP);

    // Write-merge, arbitration and read-hit decode.
    always_comb begin
        strobe_acc   = wr_strobe & ~wr_wait;
        strobe_merge = strobe_acc & (~dirty | (wr_addr[24:3] == buf_tag));
        strobe_spill = strobe_acc & dirty & (wr_addr[24:3] != buf_tag);
        // The held byte only lands once the old word has left the buffer.
        hold_merge   = hold_valid & ~commit_req & (state == S_IDLE);
        merge        = strobe_merge | hold_merge;
        if (hold_merge) begin
            m_lane = hold_addr[2:0];
            m_byte = hold_data;
            m_tag  = hold_addr[24:3];
        end else begin
            m_lane = wr_addr[2:0];
            m_byte = wr_data;
            m_tag  = wr_addr[24:3];
        end
        be_next      = buf_be | (8'd1 << m_lane);
        flush_any    = wr_flush | flush_pend;
        commit_done  = (state == S_WR_ISSUE) & ~DDRAM_BUSY;

        rd_tag       = rd_pend_addr[24:3];
        // Hold off reads while a byte is parked or landing this cycle, so a
        // read never races a write to the same word.
        rd_go        = rd_pend & ~hold_valid & ~strobe_acc;
        rd_conflict  = dirty & (rd_tag == buf_tag);
        rd_hit       = cache_valid & (rd_tag == cache_tag);
        commit_start = (state == S_IDLE) & (commit_req | (rd_go & rd_conflict));
        enter_resp   = ((state == S_IDLE) & ~commit_start & rd_go & rd_hit)
                     | ((state == S_RD_WAIT) & DDRAM_DOUT_READY);
        cache_byte   = cache_data[{rd_pend_addr[2:0], 3'b000} +: 8];
    end

    // Write buffer, hold register and commit request bookkeeping.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_data   <= '0;
            buf_be     <= '0;
            buf_tag    <= '0;
            dirty      <= 1'b0;
            commit_req <= 1'b0;
            flush_pend <= 1'b0;
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
        end else begin
            if (commit_done) begin
                dirty    <= 1'b0;
                buf_be   <= '0;
                buf_data <= '0;
            end
            if (merge) begin
                buf_data[{m_lane, 3'b000} +: 8] <= m_byte;
                buf_be  <= be_next;
                buf_tag <= m_tag;
                dirty   <= 1'b1;
            end

            if (strobe_spill) begin
                hold_valid <= 1'b1;
                hold_addr  <= wr_addr;
                hold_data  <= wr_data;
            end else if (hold_merge) begin
                hold_valid <= 1'b0;
            end

            if (commit_start) begin
                commit_req <= 1'b0;
            end
            // A coherency commit starting this cycle already takes the dirty
            // word, so a flush in the same cycle must not queue an empty one.
            if ((merge & (be_next == 8'hFF)) | strobe_spill |
                (flush_any & ~wr_wait & (strobe_merge | (dirty & ~commit_start)))) begin
                commit_req <= 1'b1;
            end

            // A flush that arrives while stalled, or alongside a spill, is
            // remembered until the buffer settles so the last bytes go out.
            if (flush_any) begin
                flush_pend <= wr_wait | strobe_spill;
            end
        end
    end

    // Port FSM: drives the Avalon command, owns the read cache and rd_data.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_IDLE;
            DDRAM_WE    <= 1'b0;
            DDRAM_RD    <= 1'b0;
            DDRAM_ADDR  <= '0;
            DDRAM_DIN   <= '0;
            DDRAM_BE    <= '0;
            cache_data  <= '0;
            cache_tag   <= '0;
            cache_valid <= 1'b0;
            rd_data     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (commit_start) begin
                        state      <= S_WR_ISSUE;
                        DDRAM_WE   <= 1'b1;
                        DDRAM_ADDR <= BASE_ADDR + {7'd0, buf_tag};
                        DDRAM_DIN  <= buf_data;
                        DDRAM_BE   <= buf_be;
                    end else if (rd_go & rd_hit) begin
                        state   <= S_RD_RESP;
                        rd_data <= cache_byte;
                    end else if (rd_go) begin
                        state      <= S_RD_ISSUE;
                        DDRAM_RD   <= 1'b1;
                        DDRAM_ADDR <= BASE_ADDR + {7'd0, rd_tag};
                    end
                end
                S_WR_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_WE <= 1'b0;
                        state    <= S_IDLE;
                        if (cache_tag == buf_tag) begin
                            cache_valid <= 1'b0;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        state    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        cache_data  <= DDRAM_DOUT;
                        cache_tag   <= rd_tag;
                        cache_valid <= 1'b1;
                        rd_data     <= DDRAM_DOUT[{rd_pend_addr[2:0], 3'b000} +: 8];
                        state       <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read request capture; busy stays up until the response cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_pend      <= 1'b0;
            rd_pend_addr <= '0;
        end else begin
            if (enter_resp) begin
                rd_pend <= 1'b0;
            end
            if (rd_req & ~rd_pend) begin
                rd_pend      <= 1'b1;
                rd_pend_addr <= rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_cas_ddram_ctrl.sv
// Scoreboard bench for cas_ddram_ctrl with a behavioural DDRAM model and a
// byte-level shadow of the tape image as the reference.
module tb_cas_ddram_ctrl;

    localparam logic [28:0] BASE = 29'h0600_0000;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [24:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_strobe;
    logic        wr_flush;
    logic        wr_wait;
    logic [24:0] rd_addr;
    logic        rd_req;
    logic        rd_busy;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        DDRAM_CLK;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    always #5 clk_sys = ~clk_sys;

    cas_ddram_ctrl dut (
        .clk_sys(clk_sys), .reset(reset),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
        .wr_flush(wr_flush), .wr_wait(wr_wait),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_busy(rd_busy),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
        .DDRAM_WE(DDRAM_WE)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_sys) cyc++;

    typedef struct {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } wr_t;
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];

    logic [63:0] mem[logic [28:0]];
    logic [7:0]  shadow[int];

    function automatic logic [63:0] init_word(logic [28:0] w);
        if (w == BASE + 29'd2) return 64'h0102030405060708;
        return {8{w[7:0]}} ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    function automatic logic [63:0] mem_get(logic [28:0] w);
        if (mem.exists(w)) return mem[w];
        return init_word(w);
    endfunction

    function automatic logic [7:0] shadow_get(int a);
        logic [63:0] w;
        if (shadow.exists(a)) return shadow[a];
        w = init_word(BASE + 29'(a / 8));
        return w[(a % 8) * 8 +: 8];
    endfunction

    function automatic logic [63:0] be_mask(logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // DDRAM slave: waitrequest per command and delayed read data.
    int          busy_len  = 0;
    bit          busy_rand = 0;
    int          rd_lat    = 10;
    int          busy_ctr  = 0;
    bit          prev_cmd  = 0;
    int          resp_ctr  = 0;
    logic [28:0] resp_addr = '0;

    always @(posedge clk_sys) begin
        #1;
        DDRAM_DOUT_READY = 1'b0;
        if ((DDRAM_WE || DDRAM_RD) && !prev_cmd)
            busy_ctr = busy_rand ? int'($urandom_range(0, 3)) : busy_len;
        prev_cmd   = DDRAM_WE || DDRAM_RD;
        DDRAM_BUSY = (busy_ctr > 0);
        if (busy_ctr > 0) busy_ctr--;
        if (resp_ctr > 0) begin
            resp_ctr--;
            if (resp_ctr == 0) begin
                DDRAM_DOUT_READY = 1'b1;
                DDRAM_DOUT       = mem_get(resp_addr);
            end
        end
    end

    // Monitor: bus transfers, write stability, scoreboard pops.
    int          we_count = 0, rd_count = 0, valid_count = 0, we_busy_cycles = 0;
    int          last_we_cyc = 0, last_rd_cyc = 0, last_valid_cyc = 0;
    logic [28:0] last_rd_addr = '0;
    bit          prev_we = 0;
    logic [28:0] h_addr;
    logic [63:0] h_din;
    logic [7:0]  h_be;

    always @(negedge clk_sys) begin
        wr_t         e;
        logic [63:0] w, m;
        if (reset) begin
            prev_we = 0;
        end else begin
            if (DDRAM_WE) begin
                if (prev_we) begin
                    chk("we_stable_addr", DDRAM_ADDR, h_addr);
                    chk("we_stable_din", DDRAM_DIN, h_din);
                    chk("we_stable_be", DDRAM_BE, h_be);
                end
                h_addr = DDRAM_ADDR; h_din = DDRAM_DIN; h_be = DDRAM_BE;
                prev_we = 1;
                if (DDRAM_BUSY) begin
                    we_busy_cycles++;
                end else begin
                    we_count++;
                    last_we_cyc = cyc;
                    prev_we = 0;
                    w = mem_get(DDRAM_ADDR);
                    for (int i = 0; i < 8; i++)
                        if (DDRAM_BE[i]) w[i*8 +: 8] = DDRAM_DIN[i*8 +: 8];
                    mem[DDRAM_ADDR] = w;
                    if (exp_wr.size() > 0) begin
                        e = exp_wr.pop_front();
                        m = be_mask(e.be);
                        chk("wr_addr", DDRAM_ADDR, e.addr);
                        chk("wr_be", DDRAM_BE, e.be);
                        chk("wr_din", DDRAM_DIN & m, e.din & m);
                    end
                end
            end else begin
                prev_we = 0;
            end
            if (DDRAM_RD && !DDRAM_BUSY) begin
                rd_count++;
                last_rd_cyc  = cyc;
                last_rd_addr = DDRAM_ADDR;
                resp_ctr     = rd_lat;
                resp_addr    = DDRAM_ADDR;
            end
            if (rd_valid) begin
                valid_count++;
                last_valid_cyc = cyc;
                if (exp_rd.size() == 0) chk("rd_unexpected", rd_valid, 0);
                else chk("rd_data", rd_data, exp_rd.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_wr_idle(output int waited);
        waited = 0;
        while (wr_wait && waited < 500) begin tick(); waited++; end
        if (waited >= 500) chk("wr_wait_timeout", wr_wait, 0);
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, output int waited);
        wait_wr_idle(waited);
        wr_addr = a; wr_data = d; wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        shadow[int'(a)] = d;
    endtask

    task automatic do_flush();
        int w;
        wait_wr_idle(w);
        wr_flush = 1'b1;
        tick();
        wr_flush = 1'b0;
        wait_wr_idle(w);
    endtask

    task automatic rd_byte(input logic [24:0] a, output int req_cyc);
        int n, c0;
        n = 0;
        while (rd_busy && n < 500) begin tick(); n++; end
        exp_rd.push_back(shadow_get(int'(a)));
        c0 = valid_count;
        rd_addr = a; rd_req = 1'b1; req_cyc = cyc;
        tick();
        rd_req = 1'b0;
        n = 0;
        while (valid_count == c0 && n < 500) begin tick(); n++; end
        if (valid_count == c0) begin
            chk("rd_timeout", valid_count, c0 + 1);
            exp_rd.delete();
        end
    endtask

    task automatic wait_we(input int target);
        int n = 0;
        while (we_count < target && n < 500) begin tick(); n++; end
        if (we_count < target) chk("we_timeout", we_count, target);
    endtask

    task automatic push_wr(input logic [28:0] a, input logic [63:0] d, input logic [7:0] b);
        wr_t e;
        e.addr = a; e.din = d; e.be = b;
        exp_wr.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"}, DDRAM_WE, 0);
        chk({tag, "_rd"}, DDRAM_RD, 0);
        chk({tag, "_burst"}, DDRAM_BURSTCNT, 1);
        chk({tag, "_addr"}, DDRAM_ADDR, 0);
        chk({tag, "_din"}, DDRAM_DIN, 0);
        chk({tag, "_be"}, DDRAM_BE, 0);
        chk({tag, "_wr_wait"}, wr_wait, 0);
        chk({tag, "_rd_busy"}, rd_busy, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          w, wsum, rc, n, c_we, c_rd, c_v, c_b;
        logic [63:0] word4, mw;
        logic [7:0]  sb;

        reset = 1'b1;
        wr_addr = '0; wr_data = '0; wr_strobe = 1'b0; wr_flush = 1'b0;
        rd_addr = '0; rd_req = 1'b0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Full word of bytes commits once.
        c_we = we_count; wsum = 0;
        push_wr(BASE, 64'h8877665544332211, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            wr_byte(25'(i), 8'((i + 1) * 17), w);
            wsum += w;
        end
        chk("t1_no_stall_before_commit", wsum, 0);
        chk("t1_wait_during_commit", wr_wait, 1);
        wait_we(c_we + 1);
        repeat (5) tick();
        chk("t1_single_write", we_count - c_we, 1);

        // Tag mismatch spills the old word, then flush commits the held byte.
        c_we = we_count;
        push_wr(BASE, 64'h0000_0000_AA00_0000, 8'h08);
        push_wr(BASE + 29'd1, 64'h0000_0000_0000_00BB, 8'h01);
        wr_byte(25'h3, 8'hAA, w);
        wr_byte(25'h8, 8'hBB, w);
        chk("t2_wait_on_spill", wr_wait, 1);
        do_flush();
        wait_we(c_we + 2);
        chk("t2_two_writes", we_count - c_we, 2);

        // Commit held off by 5 busy cycles.
        busy_len = 5;
        c_we = we_count; c_b = we_busy_cycles;
        word4 = {$urandom, $urandom};
        push_wr(BASE + 29'd4, word4, 8'hFF);
        for (int i = 0; i < 8; i++) wr_byte(25'(32 + i), word4[i*8 +: 8], w);
        wait_we(c_we + 1);
        repeat (3) tick();
        chk("t3_busy_cycles", we_busy_cycles - c_b, 5);
        chk("t3_single_write", we_count - c_we, 1);
        busy_len = 0;

        // Cold miss, then hit in the same word.
        rd_lat = 10;
        c_rd = rd_count; c_v = valid_count;
        rd_byte(25'h13, rc);
        chk("t4_miss_rd_count", rd_count - c_rd, 1);
        chk("t4_miss_rd_addr", last_rd_addr, BASE + 29'd2);
        chk("t4_miss_data", rd_data, 8'h05);
        chk("t4_one_pulse", valid_count - c_v, 1);
        tick();
        chk("t4_data_holds", rd_data, 8'h05);
        c_rd = rd_count;
        rd_byte(25'h17, rc);
        chk("t4_hit_no_rd", rd_count - c_rd, 0);
        chk("t4_hit_data", rd_data, 8'h01);
        chk("t4_hit_latency", last_valid_cyc - rc, 2);

        // Read of the dirty word forces the commit before the refill.
        c_we = we_count; c_rd = rd_count;
        push_wr(BASE + 29'd2, 64'h0000_0000_0000_00CC, 8'h01);
        wr_byte(25'h10, 8'hCC, w);
        rd_byte(25'h10, rc);
        chk("t5_write_count", we_count - c_we, 1);
        chk("t5_read_count", rd_count - c_rd, 1);
        chk("t5_write_first", last_we_cyc < last_rd_cyc, 1);
        chk("t5_data", rd_data, 8'hCC);

        // Reset in RD_WAIT: no response, lost bytes, cold cache.
        wr_byte(25'h38, 8'h99, w);
        c_rd = rd_count; c_v = valid_count;
        rd_addr = 25'h30; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        n = 0;
        while (rd_count == c_rd && n < 200) begin tick(); n++; end
        chk("t6_rd_issued", rd_count - c_rd, 1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk_reset_outputs("t6");
        tick();
        reset = 1'b0;
        shadow.delete(32'h38);
        repeat (12) tick();
        chk("t6_no_valid", valid_count - c_v, 0);
        c_we = we_count;
        do_flush();
        repeat (5) tick();
        chk("t6_buffer_lost", we_count - c_we, 0);
        c_rd = rd_count;
        rd_byte(25'h13, rc);
        chk("t6_cache_cold", rd_count - c_rd, 1);
        chk("t6_data", rd_data, 8'h05);
        c_rd = rd_count;
        rd_byte(25'h30, rc);
        chk("t6_reread", rd_count - c_rd, 1);

        // Random mix against the shadow image.
        busy_rand = 1;
        for (int k = 0; k < 400; k++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 6) begin
                wr_byte(25'($urandom_range(0, 63)), 8'($urandom), w);
            end else if (op < 7) begin
                do_flush();
            end else begin
                rd_lat = int'($urandom_range(1, 6));
                rd_byte(25'($urandom_range(0, 63)), rc);
            end
        end
        do_flush();
        repeat (10) tick();
        for (int a = 0; a < 64; a++) begin
            mw = mem_get(BASE + 29'(a / 8));
            sb = mw[(a % 8) * 8 +: 8];
            chk("final_image", sb, shadow_get(a));
        end
        chk("rd_queue_drained", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
